// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter:
// receive-FSM state encoding, frame width and baud divider arithmetic.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  // sys_clk cycles per bit, truncated the same way on both sides of the link
  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int baud);
    return calc_bit_cnt(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
// RESET_VAL sets the value both flops take while rst_n is low.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, validates the start bit at mid-bit,
// samples data and stop bits at bit centres and strobes out one byte per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);
  localparam int CNT_W    = $clog2(BIT_CNT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  uart_state_t          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 fall;

  // Idle line is high, so synchroniser and edge flop reset to 1 to avoid a false start.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_sync)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Strobes default low so each is high for exactly the cycle after its decision.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (fall) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!rx_sync) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        ST_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_sync) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        // A held-low line must go high before a new falling edge can start a frame.
        ST_BREAK: begin
          baud_cnt <= '0;
          if (rx_sync) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames, hand-written corner
// sequences and random bytes at +/-2% baud against a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  CLK_FREQ = 50_000_000;
  localparam int  BAUD     = 3_125_000;   // 16 cycles per bit keeps runtime short
  localparam int  BIT_CYC  = CLK_FREQ / BAUD;
  localparam real CLK_NS   = 20.0;
  localparam real BIT_NS   = 1.0e9 / BAUD;

  logic       sys_clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #(CLK_NS / 2.0) sys_clk = ~sys_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Output monitor: collects strobes and flags protocol violations
  logic [7:0] rx_q[$];
  int         valid_cnt  = 0;
  int         ferr_cnt   = 0;
  int         pulse_viol = 0;
  logic       prev_v     = 1'b0;
  logic       prev_f     = 1'b0;
  logic       busy_seen  = 1'b0;
  realtime    t_valid    = 0.0;
  realtime    t_fall     = 0.0;

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      valid_cnt++;
      t_valid = $realtime;
    end
    if (frame_err) ferr_cnt++;
    if ((rx_valid && frame_err) || (rx_valid && prev_v) || (frame_err && prev_f)) pulse_viol++;
    if (busy) busy_seen = 1'b1;
    prev_v = rx_valid;
    prev_f = frame_err;
  end

  task automatic send_bit(input logic b, input real bns);
    rx = b;
    #(bns);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input real bns);
    t_fall = $realtime;
    send_bit(1'b0, bns);
    for (int i = 0; i < 8; i++) send_bit(d[i], bns);
    send_bit(stop, bns);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle_bits;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t       vec[8];
  int         v0, f0;
  int         exp_good = 0;
  logic [7:0] exp_q[$];
  logic [7:0] d;
  real        bns;
  real        lat;

  initial begin
    vec[0] = '{8'h55, 1'b1, 2, 1'b1, 1'b0, 8'h55, 1'b0};
    vec[1] = '{8'hA5, 1'b1, 0, 1'b1, 1'b0, 8'hA5, 1'b0};
    vec[2] = '{8'h3C, 1'b1, 2, 1'b1, 1'b0, 8'h3C, 1'b0};
    vec[3] = '{8'hFF, 1'b1, 1, 1'b1, 1'b0, 8'hFF, 1'b0};
    vec[4] = '{8'h00, 1'b0, 3, 1'b0, 1'b1, 8'hFF, 1'b1};
    vec[5] = '{8'h01, 1'b1, 1, 1'b1, 1'b0, 8'h01, 1'b0};
    vec[6] = '{8'h80, 1'b1, 1, 1'b1, 1'b0, 8'h80, 1'b0};
    vec[7] = '{8'h6E, 1'b1, 2, 1'b1, 1'b0, 8'h6E, 1'b0};

    rx    = 1'b1;
    rst_n = 1'b0;
    #(5 * CLK_NS);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #7;
    send_bit(1'b1, 2 * BIT_NS);

    // Directed table; entry 1 -> 2 is back-to-back with zero idle
    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(vec[i].data, vec[i].stop, BIT_NS);
      if (vec[i].exp_valid) exp_good++;
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, 32'(vec[i].exp_valid));
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, 32'(vec[i].exp_ferr));
      check($sformatf("vec%0d_data", i), rx_data, vec[i].exp_data);
      check($sformatf("vec%0d_busy", i), busy, vec[i].exp_busy);
      if (i == 0) begin
        lat = (t_valid - t_fall) / CLK_NS;
        check("latency_window", (lat > 9.5 * BIT_CYC) && (lat < 9.5 * BIT_CYC + 6.0), 1'b1);
      end
      for (int k = 0; k < vec[i].idle_bits; k++) send_bit(1'b1, BIT_NS);
    end

    // Short low glitch on idle line: rejected at start-bit centre
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    #((BIT_CYC / 4) * CLK_NS);
    rx = 1'b1;
    #(2 * BIT_NS);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h81, 1'b1, BIT_NS);
    exp_good++;
    check("after_glitch_valid", valid_cnt - v0, 1);
    check("after_glitch_data", rx_data, 8'h81);
    send_bit(1'b1, BIT_NS);

    // Stop bit low, line held low 3 more bit times
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b0, BIT_NS);
    send_bit(1'b0, 3 * BIT_NS);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_no_valid", valid_cnt - v0, 0);
    check("break_data_held", rx_data, 8'h81);
    check("break_busy_held", busy, 1'b1);
    send_bit(1'b1, 2 * BIT_NS);
    check("break_release_busy", busy, 1'b0);
    check("break_release_ferr", ferr_cnt - f0, 1);
    check("break_release_valid", valid_cnt - v0, 0);
    send_frame(8'h5A, 1'b1, BIT_NS);
    exp_good++;
    check("after_break_data", rx_data, 8'h5A);
    check("after_break_valid", valid_cnt - v0, 1);
    send_bit(1'b1, BIT_NS);

    // Reset during bit 4 of 0xF0
    v0 = valid_cnt;
    f0 = ferr_cnt;
    d = 8'hF0;
    send_bit(1'b0, BIT_NS);
    for (int i = 0; i < 4; i++) send_bit(d[i], BIT_NS);
    rx = d[4];
    #(BIT_NS / 2.0);
    rst_n = 1'b0;
    #(3 * CLK_NS);
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_busy", busy, 1'b0);
    check("midreset_valid", rx_valid, 1'b0);
    check("midreset_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    #(BIT_NS / 2.0 - 3 * CLK_NS);
    for (int i = 5; i < 8; i++) send_bit(d[i], BIT_NS);
    send_bit(1'b1, 3 * BIT_NS);
    check("midreset_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    send_frame(8'h0F, 1'b1, BIT_NS);
    exp_good++;
    check("after_reset_data", rx_data, 8'h0F);
    check("after_reset_valid", valid_cnt - v0, 1);
    send_bit(1'b1, 2 * BIT_NS);

    // Random bytes with the line running 2% slow then 2% fast
    for (int s = 0; s < 2; s++) begin
      bns = (s == 0) ? BIT_NS / 0.98 : BIT_NS / 1.02;
      exp_q.delete();
      rx_q.delete();
      f0 = ferr_cnt;
      for (int n = 0; n < 128; n++) begin
        d = 8'($urandom);
        exp_q.push_back(d);
        exp_good++;
        send_frame(d, 1'b1, bns);
        if ($urandom_range(0, 3) == 0) send_bit(1'b1, bns);
      end
      send_bit(1'b1, 2 * bns);
      check($sformatf("rand%0d_count", s), rx_q.size(), exp_q.size());
      check($sformatf("rand%0d_ferr", s), ferr_cnt - f0, 0);
      for (int n = 0; n < exp_q.size() && n < rx_q.size(); n++)
        check($sformatf("rand%0d_byte%0d", s, n), rx_q[n], exp_q[n]);
    end

    check("total_valid_pulses", valid_cnt, exp_good);
    check("pulse_violations", pulse_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
